// File: rtl/traffic_sequencer_if.sv
// Handshake bundle between the traffic sequencer and its environment.
// walk_req exists only when TRAFFIC_WALK_EN is defined.
interface traffic_sequencer_if;
    logic       side_sensor;
`ifdef TRAFFIC_WALK_EN
    logic       walk_req;
`endif
    logic [6:0] light_signals;
    logic       phase_start;

    modport master (
`ifdef TRAFFIC_WALK_EN
        input  walk_req,
`endif
        input  side_sensor,
        output light_signals,
        output phase_start
    );

    modport slave (
`ifdef TRAFFIC_WALK_EN
        output walk_req,
`endif
        output side_sensor,
        input  light_signals,
        input  phase_start
    );
endinterface

// File: rtl/traffic_sequencer.sv
// Timed one-hot phase sequencer feeding the Lights decoder.
// Optional pedestrian walk phase is built in when TRAFFIC_WALK_EN is defined.
module traffic_sequencer #(
    parameter int CNT_W = 16,
    parameter int T_MG  = 8,
    parameter int T_Y   = 3,
    parameter int T_AR  = 2,
    parameter int T_SG  = 6,
    parameter int T_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_sequencer_if.master   bus
);

    typedef enum logic [6:0] {
        MG  = 7'b100_0000,
        MY  = 7'b010_0000,
        ARA = 7'b001_0000,
        SG  = 7'b000_1000,
        SY  = 7'b000_0100,
        WK  = 7'b000_0010,
        ARB = 7'b000_0001
    } phase_t;

    localparam logic [CNT_W-1:0] LD_MG = CNT_W'(T_MG - 1);
    localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] LD_SG = CNT_W'(T_SG - 1);
    localparam logic [CNT_W-1:0] LD_W  = CNT_W'(T_W - 1);

    phase_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             phase_start, phase_start_nx;
    logic             walk_pending;
    logic             expiry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB;
            timer       <= LD_AR;
            phase_start <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            phase_start <= phase_start_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        expiry   = (timer == '0);
        // An expired MG that is not released simply parks with the timer at zero.
        if (!expiry)
            timer_nx = timer - 1'b1;
        case (state)
            ARB: if (expiry) begin state_nx = MG;  timer_nx = LD_MG; end
            MG:  if (expiry && (bus.side_sensor || walk_pending)) begin
                     state_nx = MY;
                     timer_nx = LD_Y;
                 end
            MY:  if (expiry) begin state_nx = ARA; timer_nx = LD_AR; end
            ARA: if (expiry) begin state_nx = SG;  timer_nx = LD_SG; end
            SG:  if (expiry) begin state_nx = SY;  timer_nx = LD_Y;  end
            SY:  if (expiry) begin
                     state_nx = walk_pending ? WK : ARB;
                     timer_nx = walk_pending ? LD_W : LD_AR;
                 end
            WK:  if (expiry) begin state_nx = ARB; timer_nx = LD_AR; end
            default: begin
                state_nx = ARB;
                timer_nx = LD_AR;
            end
        endcase
        phase_start_nx = (state_nx != state);
    end

`ifdef TRAFFIC_WALK_EN
    logic walk_pending_nx;

    // Entering WK clears the request even if the button is still pressed on that edge.
    always_comb begin
        walk_pending_nx = walk_pending || (bus.walk_req && (state != WK));
        if ((state_nx == WK) && (state != WK))
            walk_pending_nx = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            walk_pending <= 1'b0;
        else
            walk_pending <= walk_pending_nx;
    end
`else
    assign walk_pending = 1'b0;
`endif

    assign bus.light_signals = state;
    assign bus.phase_start   = phase_start;

endmodule
